// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-multiply datapath: FSM state encoding and
// buffer sizing helpers used by the loader and the read-address control.
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        START  = 2'd2,
        RUN    = 2'd3
    } state_t;

    function automatic int calc_depth(input int m, input int n);
        return (m * m) / n;
    endfunction

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matrix_loader_wr_port.sv
// Registered write port for one slice buffer: strobe plus address/data that
// hold their last value while the strobe is low.
module matrix_loader_wr_port #(
    parameter int AW = 4,
    parameter int WW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] addr,
    input  logic [WW-1:0] data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [WW-1:0] wr_data
);

    // Register the write strobe and capture address/data only on a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= {AW{1'b0}};
            wr_data <= {WW{1'b0}};
        end else begin
            wr_en <= wr_req;
            if (wr_req) begin
                wr_addr <= addr;
                wr_data <= data;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: streams matrix A then B into slice buffers, pulses
// compute_start and waits for compute_done. Optional s_last framing check
// enabled by defining LOADER_LAST_CHK_EN.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int N  = 3,
    parameter int M  = 6,
    parameter int DW = 8,
    localparam int DEPTH = calc_depth(M, N),
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*DW-1:0] s_data,
    input  logic            s_last,
    output logic            wr_en_A,
    output logic [AW-1:0]   wr_addr_A,
    output logic [N*DW-1:0] wr_data_A,
    output logic            wr_en_B,
    output logic [AW-1:0]   wr_addr_B,
    output logic [N*DW-1:0] wr_data_B,
    output logic            compute_start,
    input  logic            compute_done,
    output logic            busy,
    output logic            err_last
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   word_cnt_r;
    logic            transfer_s;
    logic            cnt_wrap_s;
    logic            wr_req_a_s;
    logic            wr_req_b_s;

    assign transfer_s = s_valid & s_ready;
    assign cnt_wrap_s = (word_cnt_r == AW'(DEPTH - 1));
    assign wr_req_a_s = transfer_s & (state_r == LOAD_A);
    assign wr_req_b_s = transfer_s & (state_r == LOAD_B);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; compute_done only matters while in RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD_A: begin
                if (transfer_s && cnt_wrap_s) state_nxt_s = LOAD_B;
                else                          state_nxt_s = LOAD_A;
            end
            LOAD_B: begin
                if (transfer_s && cnt_wrap_s) state_nxt_s = START;
                else                          state_nxt_s = LOAD_B;
            end
            START: state_nxt_s = RUN;
            RUN: begin
                if (compute_done) state_nxt_s = LOAD_A;
                else              state_nxt_s = RUN;
            end
            default: state_nxt_s = LOAD_A;
        endcase
    end

    // State decode for handshake and status outputs.
    always_comb begin
        s_ready       = 1'b0;
        busy          = 1'b0;
        compute_start = 1'b0;
        case (state_r)
            LOAD_A, LOAD_B: s_ready = 1'b1;
            START: begin
                busy          = 1'b1;
                compute_start = 1'b1;
            end
            RUN:     busy = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // Word counter shared by both matrices; wraps together with the state advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= {AW{1'b0}};
        end else if (transfer_s) begin
            word_cnt_r <= cnt_wrap_s ? {AW{1'b0}} : word_cnt_r + AW'(1);
        end
    end

    matrix_loader_wr_port #(.AW(AW), .WW(N*DW)) u_wr_a (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req_a_s),
        .addr    (word_cnt_r),
        .data    (s_data),
        .wr_en   (wr_en_A),
        .wr_addr (wr_addr_A),
        .wr_data (wr_data_A)
    );

    matrix_loader_wr_port #(.AW(AW), .WW(N*DW)) u_wr_b (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req_b_s),
        .addr    (word_cnt_r),
        .data    (s_data),
        .wr_en   (wr_en_B),
        .wr_addr (wr_addr_B),
        .wr_data (wr_data_B)
    );

`ifdef LOADER_LAST_CHK_EN
    // Sticky framing error: s_last must mark exactly the final word of each matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_last <= 1'b0;
        end else if (transfer_s && (s_last != cnt_wrap_s)) begin
            err_last <= 1'b1;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = s_last;
    assign err_last      = 1'b0;
`endif

endmodule
